// File: rtl/mem_arbiter_if.sv
// Requestor and memory-side bundle for mem_arbiter.
// master = the arbiter; slave = the requestors plus the memory.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        busy;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rsp_addr;
  logic                      mem_en;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_rvalid;

  modport master (
    input  req, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
    output gnt, busy, done, rsp_valid, rsp_data, rsp_addr,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
    input  gnt, busy, done, rsp_valid, rsp_data, rsp_addr,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between NUM_REQ cache clients: aligned line reads
// (pipelined issue, counted returns) and single-word writes.
module mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int ARB_MODE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ISS_W = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(LINE_WORDS + 1);
  localparam int OFF_W = ISS_W + 1;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ISS_W-1:0]    iss_q, iss_d;
  logic [CNT_W-1:0]    ret_q, ret_d;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;
  logic                grant, done_p, beat;
  logic                mem_en_w, mem_wr_w;
  logic [ADDR_W-1:0]   mem_addr_w;
  logic [DATA_W-1:0]   mem_wdata_w;
  logic [ADDR_W-OFF_W-1:0] line_hi;

  assign line_hi = addr_q[ADDR_W-1:OFF_W];

  // Per-requestor unpacking of the flat request buses and one-hot status outputs.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]      = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]     = bus.req_wdata[gi*DATA_W +: DATA_W];
      assign bus.gnt[gi]       = grant && (win_idx == IDX_W'(gi));
      assign bus.busy[gi]      = (state_q != IDLE) && (owner_q == IDX_W'(gi));
      assign bus.done[gi]      = done_p && (owner_q == IDX_W'(gi));
      assign bus.rsp_valid[gi] = beat && (owner_q == IDX_W'(gi));
    end
  endgenerate

  // Search starts at 0 in fixed mode, just past the last winner in round-robin.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (ARB_MODE == 1) ? ((int'(last_q) + 1 + i) % NUM_REQ) : i;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    iss_d       = iss_q;
    ret_d       = ret_q;
    grant       = 1'b0;
    done_p      = 1'b0;
    beat        = 1'b0;
    mem_en_w    = 1'b0;
    mem_wr_w    = 1'b0;
    mem_addr_w  = '0;
    mem_wdata_w = '0;

    case (state_q)
      IDLE: begin
        if (win_found && !rst) begin
          grant   = 1'b1;
          owner_d = win_idx;
          last_d  = win_idx;
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          iss_d   = '0;
          ret_d   = '0;
          state_d = bus.req_wr[win_idx] ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_en_w   = 1'b1;
        mem_addr_w = {line_hi, iss_q, 1'b0};
        iss_d      = iss_q + 1'b1;
        if (iss_q == ISS_W'(LINE_WORDS - 1)) state_d = RD_DRAIN;
      end
      RD_DRAIN: ;
      WR: begin
        mem_en_w    = 1'b1;
        mem_wr_w    = 1'b1;
        mem_addr_w  = addr_q;
        mem_wdata_w = wdata_q;
        done_p      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Return beats count in both read states; the last one overrides the issue transition.
    if ((state_q == RD_ISSUE || state_q == RD_DRAIN) && bus.mem_rvalid &&
        (ret_q != CNT_W'(LINE_WORDS))) begin
      beat  = 1'b1;
      ret_d = ret_q + 1'b1;
      if (ret_q == CNT_W'(LINE_WORDS - 1)) begin
        done_p  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign bus.mem_en    = mem_en_w;
  assign bus.mem_wr    = mem_wr_w;
  assign bus.mem_addr  = mem_addr_w;
  assign bus.mem_wdata = mem_wdata_w;
  assign bus.rsp_data  = beat ? bus.mem_rdata : '0;
  assign bus.rsp_addr  = beat ? {line_hi, ret_q[ISS_W-1:0], 1'b0} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
    end
  end
endmodule
